// File: rtl/histogram_accumulate_unit.sv
// histogram_accumulate_unit: bins an N-lane vector against a threshold row and
// reduces the hit matrix over lanes or bins. Results can be passed through,
// emitted as counts, or accumulated per chain over a bof..eof frame.
// There are two pipeline stages (S1 input/threshold capture, S2 compute).
// Firmware and thresholds are loaded by a byte stream during the
// reconfiguration window.
module histogram_accumulate_unit #(
    parameter int N                  = 8,
    parameter int M                  = 8,
    parameter int DATA_WIDTH         = 32,
    parameter int ACC_WIDTH          = 16,
    parameter int MAX_CHAINS         = 4,
    parameter int PERSONAL_CONFIG_ID = 0,
    parameter int FUVRF_SIZE         = 4,
    localparam int CIW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tracing,
    input  logic                    valid_in,
    input  logic [1:0]              eof_in,
    input  logic [1:0]              bof_in,
    input  logic [CIW-1:0]          chainId_in,
    input  logic [7:0]              configId,
    input  logic [7:0]              configData,
    input  logic [N*DATA_WIDTH-1:0] vector_in,
    output logic [N*DATA_WIDTH-1:0] vector_out,
    output logic [CIW-1:0]          chainId_out,
    output logic                    valid_out,
    output logic [1:0]              eof_out,
    output logic [1:0]              bof_out
);

    localparam int AW        = (FUVRF_SIZE > 1) ? $clog2(FUVRF_SIZE) : 1;
    localparam int ROW_W     = M * DATA_WIDTH;
    localparam int ROW_BYTES = ROW_W / 8;
    localparam int FW_BYTES  = 3 * MAX_CHAINS;
    localparam int CFG_BYTES = FW_BYTES + FUVRF_SIZE * ROW_BYTES;
    localparam int CTR_W     = 16;
    localparam int CNT_W     = $clog2(N + 1);

    localparam logic [7:0] OP_COUNT = 8'd1;
    localparam logic [7:0] OP_ACCUM = 8'd2;
    localparam logic [7:0] AXIS_N   = 8'd2;

    // Firmware, threshold file and configuration stream state
    logic [7:0]       fwOp_q   [MAX_CHAINS];
    logic [AW-1:0]    fwAddr_q [MAX_CHAINS];
    logic [7:0]       fwAxis_q [MAX_CHAINS];
    logic [ROW_W-1:0] thr_q    [FUVRF_SIZE];
    logic [ROW_W-1:0] rowBuf_q;
    logic [CTR_W-1:0] byteCtr_q;
    logic [CTR_W-1:0] rowByteCtr_q;
    logic [AW-1:0]    rowCtr_q;

    logic             cfgActive;
    logic [CIW-1:0]   cfgIdx;
    logic [ROW_W-1:0] rowShift;

    assign cfgActive = !tracing && (configId == 8'(PERSONAL_CONFIG_ID));
    assign cfgIdx    = CIW'(byteCtr_q % CTR_W'(MAX_CHAINS));
    assign rowShift  = {rowBuf_q[ROW_W-9:0], configData};

    // Consume one config byte per selected cycle; leaving the window drops any partial row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < MAX_CHAINS; c++) begin
                fwOp_q[c]   <= '0;
                fwAddr_q[c] <= '0;
                fwAxis_q[c] <= '0;
            end
            for (int r = 0; r < FUVRF_SIZE; r++) thr_q[r] <= '0;
            rowBuf_q     <= '0;
            byteCtr_q    <= '0;
            rowByteCtr_q <= '0;
            rowCtr_q     <= '0;
        end else if (!cfgActive) begin
            byteCtr_q    <= '0;
            rowByteCtr_q <= '0;
            rowCtr_q     <= '0;
        end else if (byteCtr_q < CTR_W'(CFG_BYTES)) begin
            byteCtr_q <= byteCtr_q + 1'b1;
            if (byteCtr_q < CTR_W'(MAX_CHAINS)) begin
                fwOp_q[cfgIdx] <= configData;
            end else if (byteCtr_q < CTR_W'(2 * MAX_CHAINS)) begin
                fwAddr_q[cfgIdx] <= configData[AW-1:0];
            end else if (byteCtr_q < CTR_W'(FW_BYTES)) begin
                fwAxis_q[cfgIdx] <= configData;
            end else begin
                rowBuf_q <= rowShift;
                if (rowByteCtr_q == CTR_W'(ROW_BYTES - 1)) begin
                    thr_q[rowCtr_q] <= rowShift;
                    rowByteCtr_q    <= '0;
                    rowCtr_q        <= rowCtr_q + 1'b1;
                end else begin
                    rowByteCtr_q <= rowByteCtr_q + 1'b1;
                end
            end
        end
    end

    // S1 registers
    logic                    s1Valid_q;
    logic [N*DATA_WIDTH-1:0] s1Vec_q;
    logic [CIW-1:0]          s1Chain_q;
    logic [1:0]              s1Eof_q;
    logic [1:0]              s1Bof_q;
    logic [7:0]              s1Op_q;
    logic                    s1AxisN_q;
    logic [ROW_W-1:0]        s1Row_q;

    // S1: capture the beat together with its chain's firmware and threshold row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid_q <= 1'b0;
            s1Vec_q   <= '0;
            s1Chain_q <= '0;
            s1Eof_q   <= '0;
            s1Bof_q   <= '0;
            s1Op_q    <= '0;
            s1AxisN_q <= 1'b0;
            s1Row_q   <= '0;
        end else begin
            s1Valid_q <= valid_in && tracing;
            s1Vec_q   <= vector_in;
            s1Chain_q <= chainId_in;
            s1Eof_q   <= eof_in;
            s1Bof_q   <= bof_in;
            s1Op_q    <= fwOp_q[chainId_in];
            s1AxisN_q <= (fwAxis_q[chainId_in] == AXIS_N);
            s1Row_q   <= thr_q[fwAddr_q[chainId_in]];
        end
    end

    // Threshold words (word 0 in the top bits) and input lanes (lane 0 in the low bits)
    logic [DATA_WIDTH-1:0] thrWord [M];
    logic [DATA_WIDTH-1:0] lane    [N];
    logic [N-1:0]          hitRow  [N];

    for (genvar j = 0; j < M; j++) begin : gThr
        assign thrWord[j] = s1Row_q[ROW_W-1-j*DATA_WIDTH -: DATA_WIDTH];
    end
    for (genvar i = 0; i < N; i++) begin : gLane
        assign lane[i] = s1Vec_q[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Hit matrix: bin j covers (t[j], hi[j]]; the last bin reuses the first bin's width
    for (genvar j = 0; j < N; j++) begin : gHit
        if (j < M) begin : gBin
            logic [DATA_WIDTH-1:0] hiBound;
            if (j < M - 1) begin : gMid
                assign hiBound = thrWord[j+1];
            end else if (M == 1) begin : gOne
                assign hiBound = thrWord[0] + DATA_WIDTH'(1);
            end else begin : gLast
                assign hiBound = thrWord[M-1] + (thrWord[1] - thrWord[0]);
            end
            for (genvar i = 0; i < N; i++) begin : gCmp
                assign hitRow[j][i] = (lane[i] > thrWord[j]) && (lane[i] <= hiBound);
            end
        end else begin : gPad
            assign hitRow[j] = '0;
        end
    end

    // Accumulator file and S2 output registers
    logic [ACC_WIDTH-1:0]    acc_q [MAX_CHAINS][N];
    logic [N*DATA_WIDTH-1:0] vectorOut_q;
    logic [CIW-1:0]          chainIdOut_q;
    logic                    validOut_q;
    logic [1:0]              eofOut_q;
    logic [1:0]              bofOut_q;

    logic [CNT_W-1:0]        cnt    [N];
    logic [ACC_WIDTH-1:0]    accNew [N];
    logic [ACC_WIDTH:0]      accSum;
    logic [ACC_WIDTH-1:0]    accBase;
    logic [N*DATA_WIDTH-1:0] vectorOut_d;
    logic                    beatLive;
    logic                    validOut_d;

    assign beatLive   = s1Valid_q && tracing;
    assign validOut_d = beatLive && ((s1Op_q != OP_ACCUM) || s1Eof_q[0]);

    // S2 datapath: reduce hits, saturate accumulation, select the output vector
    always_comb begin
        vectorOut_d = s1Vec_q;
        accSum      = '0;
        accBase     = '0;
        for (int k = 0; k < N; k++) begin
            cnt[k] = '0;
            if (s1AxisN_q) begin
                for (int i = 0; i < N; i++) cnt[k] = cnt[k] + CNT_W'(hitRow[k][i]);
            end else begin
                for (int j = 0; j < N; j++) cnt[k] = cnt[k] + CNT_W'(hitRow[j][k]);
            end
            accBase   = s1Bof_q[0] ? '0 : acc_q[s1Chain_q][k];
            accSum    = {1'b0, accBase} + (ACC_WIDTH+1)'(cnt[k]);
            accNew[k] = accSum[ACC_WIDTH] ? '1 : accSum[ACC_WIDTH-1:0];
            if (s1Op_q == OP_COUNT) begin
                vectorOut_d[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(cnt[k]);
            end else if (s1Op_q == OP_ACCUM) begin
                vectorOut_d[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(accNew[k]);
            end
        end
    end

    // S2: update the chain's accumulators and register the outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < MAX_CHAINS; c++) begin
                for (int k = 0; k < N; k++) acc_q[c][k] <= '0;
            end
            vectorOut_q  <= '0;
            chainIdOut_q <= '0;
            validOut_q   <= 1'b0;
            eofOut_q     <= '0;
            bofOut_q     <= '0;
        end else begin
            validOut_q <= validOut_d;
            if (beatLive) begin
                vectorOut_q  <= vectorOut_d;
                chainIdOut_q <= s1Chain_q;
                eofOut_q     <= s1Eof_q;
                bofOut_q     <= s1Bof_q;
                if (s1Op_q == OP_ACCUM) begin
                    for (int k = 0; k < N; k++) begin
                        acc_q[s1Chain_q][k] <= s1Eof_q[0] ? '0 : accNew[k];
                    end
                end
            end
        end
    end

    assign vector_out  = vectorOut_q;
    assign chainId_out = chainIdOut_q;
    assign valid_out   = validOut_q;
    assign eof_out     = eofOut_q;
    assign bof_out     = bofOut_q;

endmodule

// File: tb/tb_histogram_accumulate_unit.sv
// Testbench for histogram_accumulate_unit: directed frames plus randomized
// traffic, checked against a reference model via an expected-output queue.
module tb_histogram_accumulate_unit;

   localparam int N    = 8;
   localparam int M    = 8;
   localparam int DW   = 32;
   localparam int ACCW = 16;
   localparam int MC   = 4;
   localparam int NR   = 4;
   localparam int ROWB = M * DW / 8;
   localparam int TOT  = 3 * MC + NR * ROWB;
   localparam int ACC_MAX = (1 << ACCW) - 1;

   logic          clk;
   logic          rst;
   logic          tracing;
   logic          valid_in;
   logic [1:0]    eof_in;
   logic [1:0]    bof_in;
   logic [1:0]    chainId_in;
   logic [7:0]    configId;
   logic [7:0]    configData;
   logic [N*DW-1:0] vector_in;
   logic [N*DW-1:0] vector_out;
   logic [1:0]    chainId_out;
   logic          valid_out;
   logic [1:0]    eof_out;
   logic [1:0]    bof_out;

   histogram_accumulate_unit #(
      .N(N), .M(M), .DATA_WIDTH(DW), .ACC_WIDTH(ACCW),
      .MAX_CHAINS(MC), .PERSONAL_CONFIG_ID(0), .FUVRF_SIZE(NR)
   ) dut (
      .clk(clk), .rst(rst), .tracing(tracing), .valid_in(valid_in),
      .eof_in(eof_in), .bof_in(bof_in), .chainId_in(chainId_in),
      .configId(configId), .configData(configData), .vector_in(vector_in),
      .vector_out(vector_out), .chainId_out(chainId_out), .valid_out(valid_out),
      .eof_out(eof_out), .bof_out(bof_out)
   );

   typedef struct {
      logic [N*DW-1:0] vec;
      logic [1:0]      ch;
      logic [1:0]      eof;
      logic [1:0]      bof;
      int              cyc;
   } exp_t;

   exp_t expQ[$];
   exp_t monE;

   int checks = 0;
   int errors = 0;
   int cycleCount = 0;

   logic [DW-1:0] mThr [NR][M];
   int            mOp  [MC];
   int            mAddr[MC];
   int            mAxis[MC];
   int            mAcc [MC][N];

   logic [7:0]    pOp  [MC];
   logic [7:0]    pAddr[MC];
   logic [7:0]    pAxis[MC];
   logic [DW-1:0] pThr [NR][M];

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter used to check the fixed two-cycle latency
   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Hard time limit so the run always ends
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: every presented output must match the oldest expected entry
   always @(negedge clk) begin
      if (!rst && valid_out) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output actual=%h expected=none", vector_out);
         end else begin
            monE = expQ.pop_front();
            checkOutput("vector_out", vector_out, monE.vec);
            checkOutput("meta_chain_eof_bof_cycle",
                        {chainId_out, eof_out, bof_out, 32'(cycleCount)},
                        {monE.ch, monE.eof, monE.bof, 32'(monE.cyc)});
         end
      end
   end

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic modelReset();
      for (int c = 0; c < MC; c++) begin
         mOp[c] = 0; mAddr[c] = 0; mAxis[c] = 0;
         for (int k = 0; k < N; k++) mAcc[c][k] = 0;
      end
      for (int r = 0; r < NR; r++)
         for (int j = 0; j < M; j++) mThr[r][j] = '0;
   endtask

   // Reference behaviour of one accepted beat, straight from the binning rules
   task automatic modelBeat(input logic [1:0] ch, input logic [1:0] bof, input logic [1:0] eof,
                            input logic [N*DW-1:0] vec);
      logic [DW-1:0] t[M];
      logic [DW-1:0] hi;
      logic [DW-1:0] x;
      int cnt[N];
      exp_t e;
      bit emit;
      for (int j = 0; j < M; j++) t[j] = mThr[mAddr[ch]][j];
      for (int k = 0; k < N; k++) cnt[k] = 0;
      for (int j = 0; j < M; j++) begin
         if (j < M - 1) hi = t[j+1];
         else hi = t[M-1] + (t[1] - t[0]);
         for (int i = 0; i < N; i++) begin
            x = vec[i*DW +: DW];
            if (x > t[j] && x <= hi) begin
               if (mAxis[ch] == 2) cnt[j]++;
               else cnt[i]++;
            end
         end
      end
      e.vec = vec;
      emit = 1'b1;
      if (mOp[ch] == 1) begin
         for (int k = 0; k < N; k++) e.vec[k*DW +: DW] = DW'(cnt[k]);
      end else if (mOp[ch] == 2) begin
         for (int k = 0; k < N; k++) begin
            mAcc[ch][k] = (bof[0] ? 0 : mAcc[ch][k]) + cnt[k];
            if (mAcc[ch][k] > ACC_MAX) mAcc[ch][k] = ACC_MAX;
            e.vec[k*DW +: DW] = DW'(mAcc[ch][k]);
            if (eof[0]) mAcc[ch][k] = 0;
         end
         emit = eof[0];
      end
      e.ch = ch; e.eof = eof; e.bof = bof; e.cyc = cycleCount + 2;
      if (emit) expQ.push_back(e);
   endtask

   task automatic applyStimulus(input logic v, input logic [1:0] ch, input logic [1:0] bof,
                                input logic [1:0] eof, input logic [N*DW-1:0] vec);
      valid_in = v; chainId_in = ch; bof_in = bof; eof_in = eof; vector_in = vec;
      if (v) modelBeat(ch, bof, eof, vec);
      stepCycle();
      valid_in = 1'b0;
   endtask

   task automatic idle(input int n);
      valid_in = 1'b0;
      repeat (n) stepCycle();
   endtask

   function automatic logic [N*DW-1:0] splat(input logic [DW-1:0] val);
      logic [N*DW-1:0] v;
      for (int i = 0; i < N; i++) v[i*DW +: DW] = val;
      return v;
   endfunction

   function automatic logic [7:0] cfgByte(input int b);
      int o;
      logic [DW-1:0] w;
      if (b < MC) return pOp[b];
      if (b < 2 * MC) return pAddr[b - MC];
      if (b < 3 * MC) return pAxis[b - 2 * MC];
      if (b >= TOT) return 8'hA5;
      o = b - 3 * MC;
      w = pThr[o / ROWB][(o % ROWB) / 4];
      return w[8*(3 - (o % 4)) +: 8];
   endfunction

   // Stream the first nBytes of the pending configuration, then close the window
   task automatic sendConfig(input int nBytes);
      idle(4);
      tracing = 1'b0;
      configId = 8'h00;
      for (int b = 0; b < nBytes; b++) begin
         configData = cfgByte(b);
         stepCycle();
      end
      configId = 8'hFF;
      configData = 8'h00;
      tracing = 1'b1;
      stepCycle();
      for (int c = 0; c < MC; c++) begin
         if (c < nBytes) mOp[c] = pOp[c];
         if (MC + c < nBytes) mAddr[c] = pAddr[c] % NR;
         if (2 * MC + c < nBytes) mAxis[c] = pAxis[c];
      end
      for (int r = 0; r < NR; r++)
         if (nBytes >= 3 * MC + (r + 1) * ROWB)
            for (int j = 0; j < M; j++) mThr[r][j] = pThr[r][j];
   endtask

   task automatic randomPending();
      logic [DW-1:0] base;
      int axSel;
      for (int c = 0; c < MC; c++) begin
         pOp[c] = 8'($urandom_range(0, 3));
         pAddr[c] = 8'($urandom_range(0, 255));
         axSel = $urandom_range(0, 2);
         pAxis[c] = 8'(axSel);
      end
      for (int r = 0; r < NR; r++) begin
         base = $urandom;
         for (int j = 0; j < M; j++) begin
            pThr[r][j] = base;
            base = base + DW'($urandom_range(1, 1000));
         end
      end
   endtask

   task automatic randomBeats(input int n);
      logic [N*DW-1:0] v;
      int r, j;
      for (int b = 0; b < n; b++) begin
         for (int i = 0; i < N; i++) begin
            r = $urandom_range(0, NR - 1);
            j = $urandom_range(0, M - 1);
            if ($urandom_range(0, 7) == 0) v[i*DW +: DW] = $urandom;
            else v[i*DW +: DW] = mThr[r][j] + DW'($urandom_range(0, 600)) - DW'(2);
         end
         applyStimulus($urandom_range(0, 4) != 0, 2'($urandom_range(0, 3)),
                       {1'b0, $urandom_range(0, 2) == 0}, {1'b0, $urandom_range(0, 2) == 0}, v);
      end
   endtask

   logic [N*DW-1:0] v15;
   logic [N*DW-1:0] v25;
   logic [N*DW-1:0] vSeq;

   initial begin
      rst = 1'b1; tracing = 1'b1; valid_in = 1'b0; eof_in = '0; bof_in = '0;
      chainId_in = '0; configId = 8'hFF; configData = '0; vector_in = '0;
      modelReset();
      v15 = splat(32'd15);
      v25 = splat(32'd25);
      for (int i = 0; i < N; i++) vSeq[i*DW +: DW] = DW'(i);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("reset_vector_out", vector_out, '0);
      checkOutput("reset_flags", {valid_out, chainId_out, eof_out, bof_out}, '0);

      // Bypass straight after reset
      applyStimulus(1'b1, 2'd2, 2'b00, 2'b00, vSeq);
      applyStimulus(1'b1, 2'd1, 2'b10, 2'b11, ~vSeq);
      idle(3);

      // Known thresholds: row 0 = 0,10,...,70; chains 0/1 count, 2/3 accumulate
      for (int r = 0; r < NR; r++)
         for (int j = 0; j < M; j++) pThr[r][j] = (r == 0) ? DW'(10 * j) : DW'($urandom);
      pOp[0] = 8'd1; pOp[1] = 8'd1; pOp[2] = 8'd2; pOp[3] = 8'd2;
      pAxis[0] = 8'd0; pAxis[1] = 8'd2; pAxis[2] = 8'd2; pAxis[3] = 8'd0;
      for (int c = 0; c < MC; c++) pAddr[c] = 8'd0;
      sendConfig(TOT + 5);

      applyStimulus(1'b1, 2'd0, 2'b00, 2'b00, v15);
      applyStimulus(1'b1, 2'd1, 2'b00, 2'b00, v15);
      applyStimulus(1'b1, 2'd0, 2'b00, 2'b00, splat(32'd80));
      applyStimulus(1'b1, 2'd0, 2'b00, 2'b00, splat(32'd0));

      // Frames: three-vector accumulate, then a single bof+eof vector
      applyStimulus(1'b1, 2'd2, 2'b01, 2'b00, v15);
      applyStimulus(1'b1, 2'd2, 2'b00, 2'b00, v15);
      applyStimulus(1'b1, 2'd2, 2'b00, 2'b01, v15);
      applyStimulus(1'b1, 2'd2, 2'b01, 2'b01, v15);

      // Interleaved chains keep separate accumulators
      applyStimulus(1'b1, 2'd2, 2'b01, 2'b00, v15);
      applyStimulus(1'b1, 2'd3, 2'b01, 2'b00, v25);
      applyStimulus(1'b0, 2'd2, 2'b00, 2'b01, v15);
      applyStimulus(1'b1, 2'd2, 2'b00, 2'b00, v15);
      applyStimulus(1'b1, 2'd3, 2'b00, 2'b01, v25);
      applyStimulus(1'b1, 2'd2, 2'b00, 2'b01, v15);

      // Saturation of a long frame
      applyStimulus(1'b1, 2'd2, 2'b01, 2'b00, v15);
      for (int n = 0; n < 8200; n++) applyStimulus(1'b1, 2'd2, 2'b00, 2'b00, v15);
      applyStimulus(1'b1, 2'd2, 2'b00, 2'b01, v15);

      // A beat caught in S1 when tracing drops must vanish without touching the accumulator
      applyStimulus(1'b1, 2'd2, 2'b01, 2'b00, v15);
      valid_in = 1'b1; chainId_in = 2'd2; bof_in = 2'b00; eof_in = 2'b00; vector_in = v15;
      stepCycle();
      valid_in = 1'b0;
      tracing = 1'b0;
      repeat (3) stepCycle();
      tracing = 1'b1;
      applyStimulus(1'b1, 2'd2, 2'b00, 2'b01, v15);

      // Randomized configuration and traffic
      randomPending();
      sendConfig(TOT);
      randomBeats(300);

      // Partial stream: firmware and row 0 land, row 1 is cut mid-row
      randomPending();
      sendConfig(3 * MC + ROWB + 10);
      randomBeats(300);

      // Asynchronous reset in the middle of a frame
      pOp[0] = 8'd1; pOp[1] = 8'd1; pOp[2] = 8'd2; pOp[3] = 8'd2;
      sendConfig(TOT);
      applyStimulus(1'b1, 2'd0, 2'b00, 2'b00, v15);
      applyStimulus(1'b1, 2'd2, 2'b01, 2'b00, v15);
      applyStimulus(1'b1, 2'd0, 2'b00, 2'b00, v25);
      valid_in = 1'b1; chainId_in = 2'd2; bof_in = 2'b00; eof_in = 2'b00; vector_in = v15;
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_reset_vector_out", vector_out, '0);
      checkOutput("async_reset_flags", {valid_out, chainId_out, eof_out, bof_out}, '0);
      expQ.delete();
      modelReset();
      valid_in = 1'b0;
      stepCycle();
      stepCycle();
      rst = 1'b0;
      applyStimulus(1'b1, 2'd2, 2'b00, 2'b01, vSeq);
      applyStimulus(1'b1, 2'd0, 2'b00, 2'b00, v25);

      idle(6);
      checkOutput("scoreboard_drained", N*DW'(expQ.size()), '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
